// File: rtl/board_sensor_scanner.sv
// rtl/board_sensor_scanner.sv - 8x8 board sensor scanner with debounce and register window
// Scans one row per SETTLE_CYCLES+2 cycles and accepts a row reading only when two consecutive scans agree.
module board_sensor_scanner #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
  parameter int          SETTLE_CYCLES = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wEn,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic [7:0]  sensor_row,
  input  logic [7:0]  sensor_col,
  output logic        board_changed
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     row;
  logic [CW-1:0]  settle_cnt;
  logic [63:0]    stable;
  logic [63:0]    prev_raw;
  logic           changed;
  logic           freeze;
  logic [15:0]    scan_count;
  logic [7:0]     col_meta;
  logic [7:0]     col_sync;

  logic           sel;
  logic [3:0]     offset;
  logic           reg_wr;
  logic [7:0]     stable_row;
  logic [7:0]     prev_row;
  logic           accept;
  logic           set_evt;
  logic [31:0]    rd_data;
  logic           unused_bits;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:0];
  assign reg_wr      = sel && wEn && (offset == 4'd3);
  assign stable_row  = stable[{row, 3'b000} +: 8];
  assign prev_row    = prev_raw[{row, 3'b000} +: 8];
  assign unused_bits = ^dataIn[31:2];

  // A row reading is accepted only if it matches the previous scan of the same row.
  assign accept  = (state == SAMPLE) && !freeze && (col_sync == prev_row);
  assign set_evt = accept && (col_sync != stable_row);

  always_comb begin
    rd_data = 32'd0;
    if (sel) begin
      case (offset)
        4'd0:    rd_data = stable[31:0];
        4'd1:    rd_data = stable[63:32];
        4'd2:    rd_data = {14'd0, freeze, changed, scan_count};
        default: rd_data = 32'd0;
      endcase
    end
  end

  // Column lines are asynchronous to the scan clock.
  always_ff @(posedge clock) begin
    col_meta <= sensor_col;
    col_sync <= col_meta;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= DRIVE;
      row        <= 3'd0;
      settle_cnt <= '0;
      sensor_row <= 8'd0;
      dataOut    <= 32'd0;
      stable     <= 64'd0;
      prev_raw   <= 64'd0;
      changed    <= 1'b0;
      freeze     <= 1'b0;
      scan_count <= 16'd0;
    end else begin
      dataOut <= rd_data;

      if (reg_wr) begin
        freeze <= dataIn[1];
        if (dataIn[0]) changed <= 1'b0;
      end
      // A change committed in the same cycle as a clear keeps the flag set.
      if (set_evt) changed <= 1'b1;

      case (state)
        DRIVE: begin
          sensor_row <= 8'b1 << row;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + CW'(1);
          if (settle_cnt == CW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
        end
        SAMPLE: begin
          if (accept) stable[{row, 3'b000} +: 8] <= col_sync;
          prev_raw[{row, 3'b000} +: 8] <= col_sync;
          if (row == 3'd7) scan_count <= scan_count + 16'd1;
          row   <= row + 3'd1;
          state <= DRIVE;
        end
        default: state <= DRIVE;
      endcase
    end
  end

  assign board_changed = changed;

endmodule
